// File: rtl/shift_cmd_sequencer_if.sv
// shift_cmd_sequencer_if: command handshake plus shift-register control bundle for shift_cmd_sequencer
interface shift_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             sr_load;
  logic             sr_serial;
  logic             sr_direction;
  logic [WIDTH-1:0] sr_parallel;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] shadow_q;
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, sr_load, sr_serial, sr_direction, sr_parallel, busy, done, err, shadow_q
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, sr_load, sr_serial, sr_direction, sr_parallel, busy, done, err, shadow_q
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: expands load/shift commands into cycle-exact shift-register controls.
// Define SHIFT_SEQ_SHADOW_EN to build shadow_q, a model of the downstream register contents.
module shift_cmd_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  shift_cmd_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  state_t           r_state, w_state;
  logic             r_load, w_load, r_serial, w_serial, r_dir, w_dir, r_done, w_done, r_err, w_err;
  logic [WIDTH-1:0] r_parallel, w_parallel, r_data, w_data, w_rev, w_orient;
  logic [CNT_W-1:0] r_left, w_left, w_n;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_rev[i] = bus.cmd_data[WIDTH-1-i];
  end
  // Data is stored in transmit order so every step just emits the LSB and shifts.
  assign w_orient = bus.cmd_op[0] ? w_rev : bus.cmd_data;
  assign w_n      = (bus.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cmd_count;
  always_comb begin
    w_state    = r_state;
    w_load     = 1'b0;
    w_serial   = 1'b0;
    w_parallel = '0;
    w_dir      = r_dir;
    w_done     = 1'b0;
    w_err      = r_err;
    w_data     = r_data;
    w_left     = r_left;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == 2'b01) begin
            w_state    = S_LOAD;
            w_load     = 1'b1;
            w_parallel = bus.cmd_data;
          end else if (bus.cmd_op[1] && w_n != '0) begin
            w_state  = S_SHIFT;
            w_dir    = bus.cmd_op[0];
            w_serial = w_orient[0];
            w_data   = w_orient >> 1;
            w_left   = w_n - 1'b1;
            w_err    = r_err | (bus.cmd_count > CNT_W'(WIDTH));
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_state = S_DONE;
        w_done  = 1'b1;
      end
      S_SHIFT: begin
        w_state  = (r_left == '0) ? S_DONE : S_SHIFT;
        w_done   = (r_left == '0);
        w_serial = (r_left == '0) ? 1'b0 : r_data[0];
        w_data   = r_data >> 1;
        w_left   = (r_left == '0) ? r_left : r_left - 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_load     <= 1'b0;
      r_serial   <= 1'b0;
      r_dir      <= 1'b0;
      r_parallel <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_left     <= '0;
    end else begin
      r_state    <= w_state;
      r_load     <= w_load;
      r_serial   <= w_serial;
      r_dir      <= w_dir;
      r_parallel <= w_parallel;
      r_done     <= w_done;
      r_err      <= w_err;
      r_data     <= w_data;
      r_left     <= w_left;
    end
  end
`ifdef SHIFT_SEQ_SHADOW_EN
  logic [WIDTH-1:0] r_shadow;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_shadow <= '0;
    else if (r_load) r_shadow <= r_parallel;
    else if (r_state == S_SHIFT) r_shadow <= r_dir ? {r_shadow[WIDTH-2:0], r_serial} : {r_serial, r_shadow[WIDTH-1:1]};
  end
  assign bus.shadow_q = r_shadow;
`else
  assign bus.shadow_q = '0;
`endif
  assign bus.cmd_ready    = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.sr_load      = r_load;
  assign bus.sr_serial    = r_serial;
  assign bus.sr_direction = r_dir;
  assign bus.sr_parallel  = r_parallel;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
endmodule
